// File: rtl/mips_encode_queue.sv
// MIPS ALU-request encoder feeding a 4-entry instruction-word FIFO.
// Illegal requests are dropped, flagged with a one-cycle pulse and counted.
module mips_encode_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic [1:0]  alu_src2,
  input  logic        is_unsigned,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        except,
  output logic [7:0]  illegal_count,
  output logic [2:0]  level
);

  localparam int unsigned Depth = 4;

  logic [31:0] mem_q [Depth];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  level_q;
  logic        except_q;
  logic [7:0]  illegal_count_q;

  logic        legal;
  logic [31:0] word;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic        accept, push, pop, illegal_acc;

  // Decode the request into an instruction word and a legality flag.
  always_comb begin
    legal  = 1'b0;
    funct  = 6'h00;
    opcode = 6'h00;
    word   = 32'h0;
    unique case (alu_src2)
      2'd0: begin
        legal = 1'b1;
        case (alu_op)
          3'd2:    funct = is_unsigned ? 6'h21 : 6'h20;
          3'd3:    funct = 6'h22;
          3'd4:    funct = 6'h24;
          3'd5:    funct = 6'h25;
          3'd6:    funct = 6'h27;
          3'd7:    funct = 6'h26;
          default: legal = 1'b0;
        endcase
        word = {6'h00, rs, rt, rd, 5'd0, funct};
      end
      2'd1: begin
        if (alu_op == 3'd2) begin
          legal  = 1'b1;
          opcode = is_unsigned ? 6'h09 : 6'h08;
        end
        // I-type destination sits in the rt field; the rt input is unused.
        word = {opcode, rs, rd, imm};
      end
      2'd2: begin
        legal = 1'b1;
        case (alu_op)
          3'd4:    opcode = 6'h0C;
          3'd5:    opcode = 6'h0D;
          3'd7:    opcode = 6'h0E;
          default: legal = 1'b0;
        endcase
        word = {opcode, rs, rd, imm};
      end
      default: legal = 1'b0;
    endcase
  end

  // Handshake qualification; a full FIFO refuses even when popping this cycle.
  always_comb begin
    in_ready    = (level_q != 3'd4);
    out_valid   = (level_q != 3'd0);
    accept      = in_valid & in_ready;
    push        = accept & legal;
    illegal_acc = accept & ~legal;
    pop         = out_valid & out_ready;
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  // Pointers, occupancy, illegal-request pulse and saturating counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      level_q         <= 3'd0;
      except_q        <= 1'b0;
      illegal_count_q <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 3'd1;
        2'b01:   level_q <= level_q - 3'd1;
        default: level_q <= level_q;
      endcase
      except_q <= illegal_acc;
      if (illegal_acc && illegal_count_q != 8'hFF) begin
        illegal_count_q <= illegal_count_q + 8'd1;
      end
    end
  end

  assign instr         = mem_q[rd_ptr_q];
  assign except        = except_q;
  assign illegal_count = illegal_count_q;
  assign level         = level_q;

endmodule

// File: tb/tb_mips_encode_queue.sv
// Directed bench for mips_encode_queue with hand-computed instruction words.
module tb_mips_encode_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src2;
  logic        is_unsigned;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        except;
  logic [7:0]  illegal_count;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  mips_encode_queue dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .alu_src2      (alu_src2),
    .is_unsigned   (is_unsigned),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .imm           (imm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .instr         (instr),
    .except        (except),
    .illegal_count (illegal_count),
    .level         (level)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] src2, input logic uns,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input logic [15:0] im);
    in_valid    = 1'b1;
    alu_op      = op;
    alu_src2    = src2;
    is_unsigned = uns;
    rs          = s;
    rt          = t;
    rd          = d;
    imm         = im;
  endtask

  logic [31:0] fill_exp [5];

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 3'd0; alu_src2 = 2'd0; is_unsigned = 1'b0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0;
    fill_exp[0] = 32'h00220821; fill_exp[1] = 32'h00221021; fill_exp[2] = 32'h00221821;
    fill_exp[3] = 32'h00222021; fill_exp[4] = 32'h00222821;

    step(); step();
    reset = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_except", 32'(except), 32'd0);
    check("rst_count", 32'(illegal_count), 32'd0);

    // ADD rs=1 rt=2 rd=3
    req(3'd2, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    in_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_instr", instr, 32'h00221820);
    check("add_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("add_pop_level", 32'(level), 32'd0);
    check("add_pop_valid", 32'(out_valid), 32'd0);

    // ORI rs=4 rd=5 imm=BEEF, rt ignored
    req(3'd5, 2'd2, 1'b0, 5'd4, 5'd7, 5'd5, 16'hBEEF);
    step();
    in_valid = 1'b0;
    check("ori_instr", instr, 32'h3485BEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Fill with five ADDU rs=1 rt=2 rd=1..5 while the consumer stalls
    for (int i = 0; i < 5; i++) begin
      req(3'd2, 2'd0, 1'b1, 5'd1, 5'd2, 5'(i + 1), 16'h0);
      check("fill_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_hold", instr, fill_exp[0]);
    // Pop while full with a request pending: no pass-through
    out_ready = 1'b1;
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    check("drain_0", instr, fill_exp[0]);
    step();
    in_valid = 1'b0;
    check("full_pop_level", 32'(level), 32'd3);
    for (int i = 1; i < 4; i++) begin
      check("drain_n", instr, fill_exp[i]);
      step();
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Illegal: SUB with sign-extended immediate
    req(3'd3, 2'd1, 1'b0, 5'd1, 5'd2, 5'd3, 16'h1234);
    step();
    in_valid = 1'b0;
    check("ill_except", 32'(except), 32'd1);
    check("ill_count", 32'(illegal_count), 32'd1);
    check("ill_level", 32'(level), 32'd0);
    step();
    check("ill_except_clear", 32'(except), 32'd0);
    // alu_op 0, src2 3, ADD with zero-ext, NOR with zero-ext
    req(3'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    check("ill_op0", 32'(illegal_count), 32'd2);
    req(3'd2, 2'd3, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    check("ill_src3", 32'(illegal_count), 32'd3);
    req(3'd2, 2'd2, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    check("ill_addzx", 32'(illegal_count), 32'd4);
    req(3'd6, 2'd2, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    check("ill_norzx", 32'(illegal_count), 32'd5);
    check("ill_level2", 32'(level), 32'd0);
    // 295 more for 300 total
    for (int i = 0; i < 295; i++) step();
    in_valid = 1'b0;
    check("ill_sat", 32'(illegal_count), 32'd255);
    check("ill_sat_except", 32'(except), 32'd1);

    // Level 2: NOR (unsigned ignored) and ADDIU
    req(3'd6, 2'd0, 1'b1, 5'd31, 5'd0, 5'd31, 16'h0);
    step();
    req(3'd2, 2'd1, 1'b1, 5'd1, 5'd9, 5'd2, 16'h8000);
    step();
    check("pp_level_pre", 32'(level), 32'd2);
    // Push ANDI with pop of NOR
    req(3'd4, 2'd2, 1'b0, 5'd3, 5'd0, 5'd4, 16'h00FF);
    out_ready = 1'b1;
    check("pp_nor", instr, 32'h03E0F827);
    step();
    check("pp_level1", 32'(level), 32'd2);
    check("pp_addiu", instr, 32'h24228000);
    // Push XOR R-type with pop of ADDIU
    req(3'd7, 2'd0, 1'b0, 5'd2, 5'd3, 5'd4, 16'h0);
    step();
    check("pp_level2", 32'(level), 32'd2);
    check("pp_andi", instr, 32'h306400FF);
    // Illegal request together with a pop: pop only, except pulses
    req(3'd2, 2'd3, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
    step();
    in_valid = 1'b0;
    check("ipop_level", 32'(level), 32'd1);
    check("ipop_except", 32'(except), 32'd1);
    check("ipop_xor", instr, 32'h00432026);
    step();
    out_ready = 1'b0;
    check("ipop_empty", 32'(level), 32'd0);

    // Reset with level 3 and handshakes in flight
    for (int i = 0; i < 3; i++) begin
      req(3'd2, 2'd0, 1'b0, 5'd1, 5'd2, 5'(i + 1), 16'h0);
      step();
    end
    check("rst3_level_pre", 32'(level), 32'd3);
    req(3'd0, 2'd3, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("rst3_level", 32'(level), 32'd0);
    check("rst3_valid", 32'(out_valid), 32'd0);
    check("rst3_count", 32'(illegal_count), 32'd0);
    check("rst3_in_ready", 32'(in_ready), 32'd1);
    step();
    check("rst3_except", 32'(except), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_encode_queue.md
MIPS_ENCODE_QUEUE -- requirements
Module: mips_encode_queue

Interface
REQ-001 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit, meaning a request is present.
REQ-004 SHALL have port in_ready, output, 1 bit, meaning a request is accepted this cycle.
REQ-005 SHALL have port alu_op, input, 3 bits: ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7.
REQ-006 SHALL have port alu_src2, input, 2 bits: 0=register, 1=sign-extended imm, 2=zero-extended imm.
REQ-007 SHALL have port is_unsigned, input, 1 bit, which selects the ADDU/ADDIU forms.
REQ-008 SHALL have ports rs, rt and rd, each input, 5 bits; SHALL have port imm, input, 16 bits.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the queue head is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, the consumer accept.
REQ-011 SHALL have port instr, output, 32 bits, carrying the queue-head instruction word.
REQ-012 SHALL have port except, output, 1 bit, a one-cycle illegal-request pulse.
REQ-013 SHALL have port illegal_count, output, 8 bits, a saturating count of illegal requests.
REQ-014 SHALL have port level, output, 3 bits, the FIFO occupancy (0..4).

Function
REQ-015 SHALL set in_ready = (level != 4); a request is accepted when in_valid & in_ready.
REQ-016 SHALL encode legal R-type requests (alu_src2=0) as opcode 0x00, rs, rt, rd, shamt 0, then funct.
REQ-017 SHALL use these R-type funct values: ADD 0x20 (ADDU 0x21 when is_unsigned), SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
REQ-018 SHALL ignore is_unsigned for every R-type op other than ADD.
REQ-019 SHALL encode I-type requests as opcode, rs, then rd in bits [20:16], then imm in [15:0]; the rt input is ignored.
REQ-020 SHALL use these I-type legal combinations: src2=1 with ADD gives opcode 0x08 (0x09 if is_unsigned); src2=2 with AND gives 0x0C, OR gives 0x0D, XOR gives 0x0E.
REQ-021 SHALL treat every other combination as illegal: alu_op 0, 1 or >7, src2=3, src2=1 with non-ADD, and src2=2 with ADD, SUB or NOR.
REQ-022 SHALL NOT enqueue an accepted illegal request; instead it SHALL assert except for exactly the next cycle and increment illegal_count, saturating at 255.
REQ-023 SHALL NOT assert except or count anything for an illegal request that is not accepted (FIFO full).
REQ-024 SHALL make each legal accepted request visible at the head with one-cycle latency when the FIFO is empty (registered FIFO, no bypass).
REQ-025 SHALL store requests in a 4-entry FIFO with 2-bit read/write pointers that wrap 3->0.
REQ-026 SHALL pop the head when out_valid & out_ready; out_valid = (level != 0).
REQ-027 SHALL hold instr stable while out_valid & !out_ready; its value is don't-care when empty.
REQ-028 SHALL, on a simultaneous legal push and pop, leave level unchanged and advance both pointers.
REQ-029 SHALL, with level=4, deassert in_ready even if a pop occurs in the same cycle (no full pass-through).
REQ-030 SHALL, on a simultaneous illegal accepted request and pop, pop only and pulse except.

Reset
REQ-031 SHALL, while reset=1 at a clock edge, clear level, the pointers, except and illegal_count to 0; out_valid=0 and in_ready=1 follow.
REQ-032 SHALL let reset take priority over any simultaneous push or pop; FIFO contents are discarded.
REQ-033 SHALL ignore in-flight handshakes in the reset cycle; no except pulse follows reset.

Verification
REQ-034 Bench SHALL cover: reset, then push ADD (src2=0, unsigned 0) rs=1 rt=2 rd=3 -> next cycle out_valid=1, instr=0x00221820.
REQ-035 Bench SHALL cover: push ORI rs=4 rd=5 imm=0xBEEF (op=5, src2=2) -> instr=0x3485BEEF.
REQ-036 Bench SHALL cover: push 5 legal requests with out_ready=0 -> level=4, in_ready=0 after the 4th, 5th not accepted; then drain gives the 4 words in order.
REQ-037 Bench SHALL cover: push SUB with src2=1 -> except=1 for one cycle, illegal_count=1, level unchanged; 300 illegal pushes give illegal_count=255.
REQ-038 Bench SHALL cover: level=2 with simultaneous push and pop -> level stays 2; pointers wrap after more than 4 total pushes with order preserved.
REQ-039 Bench SHALL cover: reset asserted with level=3 -> next cycle level=0, out_valid=0, illegal_count=0.
